// File: rtl/fp_unit_issue_ctrl.sv
// Issue/sequencing stage around the combinational FPU: holds operands stable for a
// per-opcode number of cycles, then captures the result for a valid/ready writeback.
module fp_unit_issue_ctrl #(
   parameter int unsigned LAT_ADD = 2,
   parameter int unsigned LAT_MUL = 3,
   parameter int unsigned LAT_DIV = 10
) (
   input  logic        in_clk,
   input  logic        in_rst,
   input  logic        in_valid,
   output logic        out_ready,
   input  logic [3:0]  in_FPU_Op,
   input  logic [1:0]  in_fmt,
   input  logic        in_addsub_ctrl,
   input  logic [2:0]  in_ctrl_minmax_sgnj_cmp,
   input  logic [31:0] in_rs1,
   input  logic [31:0] in_rs2,
   input  logic [4:0]  in_rd,
   output logic [31:0] out_fpu_rs1,
   output logic [31:0] out_fpu_rs2,
   output logic [3:0]  out_fpu_op,
   output logic [1:0]  out_fpu_fmt,
   output logic        out_fpu_addsub,
   output logic [2:0]  out_fpu_ctrl,
   input  logic [63:0] in_fpu_data,
   output logic        out_valid,
   input  logic        in_ready,
   output logic [63:0] out_data,
   output logic [4:0]  out_rd,
   output logic        out_int_wb,
   output logic        out_busy
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EXEC = 2'd1,
      S_DONE = 2'd2
   } state_t;

   localparam logic [3:0] CNT_ADD = 4'(LAT_ADD - 1);
   localparam logic [3:0] CNT_MUL = 4'(LAT_MUL - 1);
   localparam logic [3:0] CNT_DIV = 4'(LAT_DIV - 1);

   state_t      r_state;
   state_t      w_state_nxt;
   logic [3:0]  r_cnt;
   logic [3:0]  w_cnt_nxt;
   logic [3:0]  w_lat_m1;
   logic [4:0]  r_rd_pend;
   logic [31:0] r_fpu_rs1;
   logic [31:0] r_fpu_rs2;
   logic [3:0]  r_fpu_op;
   logic [1:0]  r_fpu_fmt;
   logic        r_fpu_addsub;
   logic [2:0]  r_fpu_ctrl;
   logic [63:0] r_data;
   logic [4:0]  r_rd;
   logic        r_int_wb;
   logic        w_ready;
   logic        w_accept;
   logic        w_capture;

   // Counter preload is latency minus one so the capture lands exactly L edges after accept.
   always_comb begin
      w_lat_m1 = 4'd0;
      case (in_FPU_Op)
         4'b0000: w_lat_m1 = CNT_ADD;
         4'b0001: w_lat_m1 = CNT_MUL;
         4'b0010: w_lat_m1 = CNT_DIV;
         default: w_lat_m1 = 4'd0;
      endcase
   end

   // NOTE: every signal gets a default before the case so no latch is inferred.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_ready     = 1'b0;
      w_capture   = 1'b0;
      case (r_state)
         S_IDLE: w_ready = 1'b1;
         S_EXEC: begin
            if (r_cnt == 4'd0) begin
               w_capture   = 1'b1;
               w_state_nxt = S_DONE;
            end else begin
               w_cnt_nxt = r_cnt - 4'd1;
            end
         end
         S_DONE: begin
            if (in_ready) begin
               w_ready     = 1'b1;
               w_state_nxt = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
      w_accept = in_valid & w_ready;
      if (w_accept) begin
         w_state_nxt = S_EXEC;
         w_cnt_nxt   = w_lat_m1;
      end
   end

   // NOTE: state registers use non-blocking assignments so all flops update together.
   always_ff @(posedge in_clk) begin
      if (in_rst) begin
         r_state      <= S_IDLE;
         r_cnt        <= 4'd0;
         r_rd_pend    <= 5'd0;
         r_fpu_rs1    <= 32'd0;
         r_fpu_rs2    <= 32'd0;
         r_fpu_op     <= 4'd0;
         r_fpu_fmt    <= 2'd0;
         r_fpu_addsub <= 1'b0;
         r_fpu_ctrl   <= 3'd0;
         r_data       <= 64'd0;
         r_rd         <= 5'd0;
         r_int_wb     <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         if (w_accept) begin
            r_rd_pend    <= in_rd;
            r_fpu_rs1    <= in_rs1;
            r_fpu_rs2    <= in_rs2;
            r_fpu_op     <= in_FPU_Op;
            r_fpu_fmt    <= in_fmt;
            r_fpu_addsub <= in_addsub_ctrl;
            r_fpu_ctrl   <= in_ctrl_minmax_sgnj_cmp;
         end
         if (w_capture) begin
            r_data   <= in_fpu_data;
            r_rd     <= r_rd_pend;
            r_int_wb <= (r_fpu_op == 4'b0100) || (r_fpu_op == 4'b0110);
         end
      end
   end

   assign out_ready      = w_ready;
   assign out_valid      = (r_state == S_DONE);
   assign out_busy       = (r_state != S_IDLE);
   assign out_fpu_rs1    = r_fpu_rs1;
   assign out_fpu_rs2    = r_fpu_rs2;
   assign out_fpu_op     = r_fpu_op;
   assign out_fpu_fmt    = r_fpu_fmt;
   assign out_fpu_addsub = r_fpu_addsub;
   assign out_fpu_ctrl   = r_fpu_ctrl;
   assign out_data       = r_data;
   assign out_rd         = r_rd;
   assign out_int_wb     = r_int_wb;

endmodule
